// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment scanner.
// Values are double-buffered (pending -> active) and only swap at the frame
// boundary, so a frame never mixes old and new digits.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 16000,
  parameter int BLANK          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_C  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  // XOR masks turning active-high internal levels into pin levels.
  localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                slotEnd;
  logic                frameEnd;

  logic [4*DIGITS-1:0] activeVal;
  logic [DIGITS-1:0]   activeDp;
  logic [DIGITS-1:0]   activeEn;
  logic [4*DIGITS-1:0] pendVal;
  logic [DIGITS-1:0]   pendDp;
  logic [DIGITS-1:0]   pendEn;
  logic                pend;

  logic [3:0]          nibble;
  logic                digDp;
  logic                digEn;
  logic                higherZero;
  logic                suppress;
  logic                anOn;
  logic [6:0]          segRaw;
  logic                dpRaw;
  logic [DIGITS-1:0]   anRaw;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
    endcase
  endfunction

  assign slotEnd  = (cnt == CNT_LAST);
  assign frameEnd = slotEnd && (idx == IDX_LAST);

  // Slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slotEnd) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer; a load landing on the boundary bypasses pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      activeVal <= '0;
      activeDp  <= '0;
      activeEn  <= '0;
      pendVal   <= '0;
      pendDp    <= '0;
      pendEn    <= '0;
      pend      <= 1'b0;
    end else if (frameEnd && load) begin
      activeVal <= value;
      activeDp  <= dp;
      activeEn  <= digit_en;
      pend      <= 1'b0;
    end else if (load) begin
      pendVal   <= value;
      pendDp    <= dp;
      pendEn    <= digit_en;
      pend      <= 1'b1;
    end else if (frameEnd && pend) begin
      activeVal <= pendVal;
      activeDp  <= pendDp;
      activeEn  <= pendEn;
      pend      <= 1'b0;
    end
  end

  // Select the current digit, apply leading-zero suppression and blanking.
  always_comb begin
    nibble     = '0;
    digDp      = 1'b0;
    digEn      = 1'b0;
    higherZero = 1'b1;
    suppress   = 1'b0;
    anRaw      = '0;
    // Walk from the top digit down so higherZero covers this nibble and all above it.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higherZero = higherZero & (activeVal[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        nibble   = activeVal[4*i +: 4];
        digDp    = activeDp[i];
        digEn    = activeEn[i];
        suppress = lz_blank & higherZero & (i != 0);
      end
    end
    anOn = (cnt >= BLANK_C) & digEn;
    for (int i = 0; i < DIGITS; i++) begin
      anRaw[i] = anOn & (idx == IDX_W'(i));
    end
    segRaw = (anOn & ~suppress) ? glyph(nibble) : 7'h00;
    dpRaw  = anOn & digDp;
  end

  // Registered pin outputs with polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_INV;
      dp_out     <= DP_INV;
      an         <= AN_INV;
      frame_tick <= 1'b0;
    end else begin
      seg        <= segRaw ^ SEG_INV;
      dp_out     <= dpRaw ^ DP_INV;
      an         <= anRaw ^ AN_INV;
      frame_tick <= frameEnd;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIGITS=4, SCAN_DIV=4, BLANK=1.
// An active-low and an active-high instance share stimulus; the second must
// always be the bitwise complement of the first.
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        lzBlank;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digitEn;

  logic [6:0]  seg, segH;
  logic        dpOut, dpOutH;
  logic [3:0]  an, anH;
  logic        frameTick, frameTickH;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [27:0] segs;   // {slot3, slot2, slot1, slot0} active-low segments
    logic [15:0] ans;    // {slot3, ..., slot0} active-low anodes
    logic [3:0]  dps;    // bit s = dp_out during slot s
  } vec_t;

  vec_t vecs[11];

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dutL (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digitEn),
    .lz_blank(lzBlank), .load(load), .seg(seg), .dp_out(dpOut), .an(an),
    .frame_tick(frameTick)
  );

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dutH (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digitEn),
    .lz_blank(lzBlank), .load(load), .seg(segH), .dp_out(dpOutH), .an(anH),
    .frame_tick(frameTickH)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPol(input string tag);
    logic [6:0] nSeg;
    logic [3:0] nAn;
    logic       nDp;
    nSeg = ~seg;
    nAn  = ~an;
    nDp  = ~dpOut;
    check({tag, " pol seg"}, {25'b0, segH}, {25'b0, nSeg});
    check({tag, " pol an"}, {28'b0, anH}, {28'b0, nAn});
    check({tag, " pol dp"}, {31'b0, dpOutH}, {31'b0, nDp});
    check({tag, " pol tick"}, {31'b0, frameTickH}, {31'b0, frameTick});
  endtask

  task automatic checkDark(input string tag, input logic expTick);
    check({tag, " an"}, {28'b0, an}, 32'hF);
    check({tag, " seg"}, {25'b0, seg}, 32'h7F);
    check({tag, " dp"}, {31'b0, dpOut}, 32'h1);
    check({tag, " tick"}, {31'b0, frameTick}, {31'b0, expTick});
    checkPol(tag);
  endtask

  // Run n cycles after reset release with nothing loaded: all dark, tick every 16.
  task automatic darkRun(input int n);
    for (int c = 1; c <= n; c++) begin
      step();
      checkDark($sformatf("dark c%0d", c), (c % 16) == 0);
    end
  endtask

  task automatic setInputs(input int v, input bit withLz);
    value   = vecs[v].value;
    dp      = vecs[v].dp;
    digitEn = vecs[v].en;
    if (withLz) lzBlank = vecs[v].lz;
  endtask

  task automatic loadVec(input int v);
    setInputs(v, 1'b1);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frameTick && n < 40);
    check("tick wait", {31'b0, frameTick}, 32'h1);
  endtask

  // Starts at the sample where frame_tick is high; checks one full frame and
  // ends on the next tick. Optional loads are issued at offsets offA / offB.
  task automatic checkFrame(input int v, input int offA, input int vA, input int offB, input int vB);
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    int s, c;
    string tag;
    for (int o = 1; o <= 16; o++) begin
      step();
      s = (o - 1) / SCAN_DIV;
      c = (o - 1) % SCAN_DIV;
      if (c < BLANK) begin
        eAn  = 4'hF;
        eSeg = 7'h7F;
        eDp  = 1'b1;
      end else begin
        eAn  = vecs[v].ans[4*s +: 4];
        eSeg = vecs[v].segs[7*s +: 7];
        eDp  = vecs[v].dps[s];
      end
      tag = $sformatf("v%0d o%0d", v, o);
      check({tag, " an"}, {28'b0, an}, {28'b0, eAn});
      check({tag, " seg"}, {25'b0, seg}, {25'b0, eSeg});
      check({tag, " dp"}, {31'b0, dpOut}, {31'b0, eDp});
      check({tag, " tick"}, {31'b0, frameTick}, {31'b0, logic'(o == 16)});
      checkPol(tag);
      if (o == offA) begin
        setInputs(vA, 1'b0);
        load = 1'b1;
      end else if (o == offB) begin
        setInputs(vB, 1'b0);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h12AF, 4'b0100, 4'hF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 16'h7BDE, 4'b1011};
    vecs[1]  = '{16'h1111, 4'b0000, 4'hF, 1'b0, {7'h79, 7'h79, 7'h79, 7'h79}, 16'h7BDE, 4'b1111};
    vecs[2]  = '{16'h2222, 4'b0000, 4'hF, 1'b0, {7'h24, 7'h24, 7'h24, 7'h24}, 16'h7BDE, 4'b1111};
    vecs[3]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 16'h7BDE, 4'b1111};
    vecs[4]  = '{16'h0000, 4'b0000, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'h7BDE, 4'b1111};
    vecs[5]  = '{16'h0050, 4'b0000, 4'hF, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 16'h7BDE, 4'b1111};
    vecs[6]  = '{16'h8421, 4'b1111, 4'b1010, 1'b0, {7'h00, 7'h7F, 7'h24, 7'h7F}, 16'h7FDF, 4'b0101};
    vecs[7]  = '{16'h0300, 4'b1000, 4'hF, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 16'h7BDE, 4'b0111};
    vecs[8]  = '{16'h3456, 4'b0000, 4'hF, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 16'h7BDE, 4'b1111};
    vecs[9]  = '{16'hCDEB, 4'b0000, 4'hF, 1'b0, {7'h46, 7'h21, 7'h06, 7'h03}, 16'h7BDE, 4'b1111};
    vecs[10] = '{16'h7089, 4'b0000, 4'hF, 1'b0, {7'h78, 7'h40, 7'h00, 7'h10}, 16'h7BDE, 4'b1111};

    rst     = 1'b1;
    load    = 1'b0;
    lzBlank = 1'b0;
    value   = '0;
    dp      = '0;
    digitEn = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      checkDark($sformatf("reset c%0d", i), 1'b0);
    end
    rst = 1'b0;
    darkRun(36);

    // Basic scan, with the tearing loads issued mid-frame.
    waitTick();
    loadVec(0);
    waitTick();
    checkFrame(0, 3, 1, 5, 2);
    checkFrame(2, -1, 0, -1, 0);

    // Leading zeros, enable mask and glyph coverage.
    for (int v = 3; v <= 10; v++) begin
      loadVec(v);
      waitTick();
      checkFrame(v, -1, 0, -1, 0);
    end

    // Mid-frame load then a load on the boundary cycle: boundary load wins and
    // nothing stale is left pending.
    checkFrame(10, 5, 8, 15, 9);
    checkFrame(9, -1, 0, -1, 0);
    checkFrame(9, -1, 0, -1, 0);

    // Reset mid-slot with a load strobe active.
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    setInputs(0, 1'b1);
    load = 1'b1;
    step();
    checkDark("rst mid 0", 1'b0);
    step();
    checkDark("rst mid 1", 1'b0);
    rst  = 1'b0;
    load = 1'b0;
    darkRun(36);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. Takes a packed hexadecimal value, per-digit decimal-point and enable masks, and scans the digits one at a time. Each digit is shown for a programmable number of clocks, with an anti-ghosting blank at the start of each slot. New values are double-buffered and take effect only at a frame boundary, so a digit never shows a mix of old and new values. It sits between the datapath that produces values and the board's segment/anode pins.

## Interface

Parameters:
- DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV, 16000, clock cycles per digit slot (>= BLANK+1)
- BLANK, 2, cycles at start of each slot with all anodes off (>= 0)
- SEG_ACTIVE_LOW, 1, 1: seg/dp_out driven low = lit
- AN_ACTIVE_LOW, 1, 1: an driven low = digit selected

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; synchronous and active-high
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
- dp  in  DIGITS  decimal point per digit
- digit_en  in  DIGITS  0 = digit fully dark (anode off)
- lz_blank  in  1  1 = suppress leading zeros
- load  in  1  one-cycle strobe capturing value/dp/digit_en
- seg  out  7  segments, bit0=a … bit6=g
- dp_out  out  1  decimal-point segment
- an  out  DIGITS  anode select, one-hot when active
- frame_tick  out  1  one-cycle pulse at frame wrap

## Operation

- Prescaler cnt counts 0..SCAN_DIV-1. Digit index idx advances when cnt = SCAN_DIV-1. It wraps from DIGITS-1 to 0.
- Wrap cycle (cnt = SCAN_DIV-1 and idx = DIGITS-1) is the frame boundary. frame_tick is asserted in the cycle after it.
- Buffering:
  - load copies value/dp/digit_en into the pending register and sets pend.
  - At the frame boundary, if pend is set, pending is copied to active and pend is cleared.
  - load on the boundary cycle itself: the inputs go straight to active and pend is cleared.
  - Repeated loads within a frame: the last one wins.
- Glyphs, active-high g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero suppression (lz_blank=1): digit i>0 has its segments blanked when its nibble and all higher nibbles of active are 0. The anode and dp still follow normal rules. Digit 0 is never suppressed. lz_blank is sampled live, not buffered.
- Anode for digit idx is on iff cnt >= BLANK and active digit_en[idx]=1. All other anodes are off.
- Segments and dp show active nibble/dp for idx, after suppression. Segments are all off while the anode is off.
- Polarity: final seg/dp_out are inverted when SEG_ACTIVE_LOW=1; an is inverted when AN_ACTIVE_LOW=1.

## Timing

- All outputs are registered, one cycle after the (cnt, idx, active) state that produces them.
- Reset (rst=1 at an edge, including mid-frame or mid-load):
  - cnt=0, idx=0, active=0, pending=0, pend=0.
  - seg all off, dp_out off, an all off, frame_tick=0.
  - load is ignored while rst=1.
- First cycle after reset release:
  - Digit 0 anode turns on at output cycle BLANK+1 (outputs show the active=0 digit_en, so it stays dark until the first load reaches active).
- Frame period is DIGITS*SCAN_DIV cycles. A load made in frame k is visible from the first slot of frame k+1.
- BLANK=0 gives no dark gap. Anodes then switch directly between adjacent digits on slot change.
- DIGITS=1: idx stays 0, and every slot end is a frame boundary.

## Test plan

Common parameters: DIGITS=4, SCAN_DIV=4, BLANK=1, both active-low.

- **Reset:** hold rst 3 cycles.
  - Required: an=1111, seg=1111111, dp_out=1, frame_tick=0.
  - Assert rst again mid-slot: the same values appear at the next edge.
- **Basic scan:** load value=16'h12AF, dp=4'b0100, digit_en=4'hF.
  - Each slot gives 1 blank cycle then 3 cycles with an low on one digit, in order 1110, 1101, 1011, 0111.
  - seg=~7F'h71, ~77, ~5B, ~06. dp_out=0 only on digit 2.
  - frame_tick pulses once every 16 cycles.
- **Tearing:** load 16'h1111 mid-frame, then 16'h2222 two cycles later.
  - Rest of the current frame still shows the old value.
  - Next frame shows 2 on every digit (~5B). 1 is never shown.
- **Boundary load:** load on the exact wrap cycle.
  - The new value appears from the first slot of the next frame. pend reads 0 after it.
- **Leading zeros:** value=16'h0050, lz_blank=1.
  - Digits 3 and 2 have segments off with anodes still cycling.
  - Digit 1 shows 5 and digit 0 shows 0.
  - value=0: only digit 0 is lit, showing 0.
- **Enable mask and polarity:** digit_en=4'b1010.
  - Digits 0 and 2 are never selected.
  - Rerun with SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0: all outputs are bitwise complements of the active-low run.
